// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one bypassing BRAM between instruction fetch (port 0)
// and data memory (port 1). Optional grant/stall counters: define BRAM_ARB_STATS_EN.
module bram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  port0Request,
  input  logic                  port0Write,
  input  logic [ADDR_WIDTH-1:0] port0Address,
  input  logic [DATA_WIDTH-1:0] port0WriteData,
  input  logic                  port1Request,
  input  logic                  port1Write,
  input  logic [ADDR_WIDTH-1:0] port1Address,
  input  logic [DATA_WIDTH-1:0] port1WriteData,
  output logic                  port0Grant,
  output logic                  port1Grant,
  output logic                  port0ReadValid,
  output logic                  port1ReadValid,
  output logic [DATA_WIDTH-1:0] port0ReadData,
  output logic [DATA_WIDTH-1:0] port1ReadData,
  output logic                  bramReadEnable,
  output logic [ADDR_WIDTH-1:0] bramReadAddress,
  output logic                  bramWriteEnable,
  output logic [ADDR_WIDTH-1:0] bramWriteAddress,
  output logic [DATA_WIDTH-1:0] bramWriteData,
  input  logic [DATA_WIDTH-1:0] bramReadData
`ifdef BRAM_ARB_STATS_EN
  ,
  output logic [15:0]           port0GrantCount,
  output logic [15:0]           port1GrantCount,
  output logic [15:0]           hazardStallCount
`endif
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

  state_e                state_q, state_d;
  logic                  prio_q, prio_d;
  logic                  inflight_port_q, inflight_port_d;
  logic [ADDR_WIDTH-1:0] inflight_addr_q, inflight_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

  logic [1:0]            hazard, elig, grant;
  logic                  gsel, g_write, rd_grant, wr_grant;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_data;

  always_comb begin
    // A write to the address of the read now returning would leak through the
    // BRAM bypass into that read's data, so hold it off for one cycle.
    hazard[0] = (state_q == RESP) && port0Request && port0Write &&
                (port0Address == inflight_addr_q);
    hazard[1] = (state_q == RESP) && port1Request && port1Write &&
                (port1Address == inflight_addr_q);
    elig      = {port1Request, port0Request} & ~hazard;

    grant = 2'b00;
    if (!reset) begin
      case (elig)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end

    gsel     = grant[1];
    g_write  = gsel ? port1Write     : port0Write;
    g_addr   = gsel ? port1Address   : port0Address;
    g_data   = gsel ? port1WriteData : port0WriteData;
    rd_grant = (|grant) && !g_write;
    wr_grant = (|grant) && g_write;

    state_d         = rd_grant ? RESP : IDLE;
    prio_d          = (|grant) ? ~gsel : prio_q;
    inflight_port_d = rd_grant ? gsel   : inflight_port_q;
    inflight_addr_d = rd_grant ? g_addr : inflight_addr_q;
    rd_addr_d       = rd_grant ? g_addr : rd_addr_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      rd_addr_q <= rd_addr_d;
    end
    inflight_port_q <= inflight_port_d;
    inflight_addr_q <= inflight_addr_d;
  end

  assign port0Grant       = grant[0];
  assign port1Grant       = grant[1];
  assign bramReadEnable   = rd_grant;
  assign bramReadAddress  = reset ? '0 : rd_addr_d;
  assign bramWriteEnable  = wr_grant;
  assign bramWriteAddress = g_addr;
  assign bramWriteData    = g_data;
  assign port0ReadValid   = (state_q == RESP) && !inflight_port_q;
  assign port1ReadValid   = (state_q == RESP) &&  inflight_port_q;
  assign port0ReadData    = bramReadData;
  assign port1ReadData    = bramReadData;

`ifdef BRAM_ARB_STATS_EN
  logic [15:0] gcnt0_q, gcnt0_d, gcnt1_q, gcnt1_d, hzcnt_q, hzcnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  always_comb begin
    gcnt0_d = sat_inc(gcnt0_q, grant[0]);
    gcnt1_d = sat_inc(gcnt1_q, grant[1]);
    hzcnt_d = sat_inc(hzcnt_q, (|hazard) && !reset);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
      hzcnt_q <= '0;
    end else begin
      gcnt0_q <= gcnt0_d;
      gcnt1_q <= gcnt1_d;
      hzcnt_q <= hzcnt_d;
    end
  end

  assign port0GrantCount  = gcnt0_q;
  assign port1GrantCount  = gcnt1_q;
  assign hazardStallCount = hzcnt_q;
`endif

endmodule
